cic_dec_var: RTL and testbench

- Multi-channel CIC decimator with a runtime-selectable decimation rate.
- Replaces the fixed-rate decimators in the DDC receive chain.
- Adds a per-rate output normalising shift, round-half-up with saturation, warm-up output suppression, and a clean flush on rate change or reset.
- Sits between the NCO/mixer output (in_strobe rate) and the downstream FIR decimator.

---
 rtl/cic_dec_var_if.sv | 24 ++
 rtl/cic_dec_var.sv | 148 ++++++++++++++
 tb/tb_cic_dec_var.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cic_dec_var_if.sv
// cic_dec_var_if: configuration, sample and status signals of the variable-rate CIC decimator.
interface cic_dec_var_if #(
    parameter int CHANNELS  = 2,
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18
);
    logic [6:0]                    rate;
    logic [5:0]                    shift;
    logic                          in_strobe;
    logic [CHANNELS*IN_WIDTH-1:0]  in_data;
    logic                          out_strobe;
    logic [CHANNELS*OUT_WIDTH-1:0] out_data;
    logic                          busy;

    modport master (
        output rate, shift, in_strobe, in_data,
        input  out_strobe, out_data, busy
    );

    modport slave (
        input  rate, shift, in_strobe, in_data,
        output out_strobe, out_data, busy
    );
endinterface

// File: rtl/cic_dec_var.sv
// cic_dec_var: multi-channel CIC decimator with runtime rate, rounding/saturating output shift,
// warm-up output suppression and a one-clock flush whenever rate or shift changes.
module cic_dec_var #(
    parameter int CHANNELS  = 2,
    parameter int STAGES    = 5,
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 18,
    parameter int MAX_DEC   = 40,
    parameter int ACC_WIDTH = 48,
    parameter int WARMUP    = 2*STAGES
) (
    input logic          clock_i,
    input logic          reset_n_i,
    cic_dec_var_if.slave cic_if
);
    localparam int WC_W = $clog2(WARMUP+1);
    localparam logic [6:0] MIN_R = 7'd2;
    localparam logic [6:0] MAX_R = 7'(MAX_DEC);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);

    typedef enum logic [1:0] {FLUSH, WARMUP_S, RUN} state_t;

    state_t                        state_q, state_d;
    logic [6:0]                    active_rate_q, active_rate_d;
    logic [5:0]                    active_shift_q, active_shift_d;
    logic [6:0]                    sample_no_q, sample_no_d;
    logic [WC_W-1:0]               wcnt_q, wcnt_d;
    logic                          dump_q, dump_d;
    logic                          emit_q, emit_d;
    logic                          out_strobe_q, out_strobe_d;
    logic [CHANNELS*OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic signed [ACC_WIDTH-1:0]   integ_q [CHANNELS][STAGES];
    logic signed [ACC_WIDTH-1:0]   integ_d [CHANNELS][STAGES];
    logic signed [ACC_WIDTH-1:0]   comb_q  [CHANNELS][STAGES];
    logic signed [ACC_WIDTH-1:0]   comb_d  [CHANNELS][STAGES];
    logic signed [ACC_WIDTH-1:0]   dly_q   [CHANNELS][STAGES];
    logic signed [ACC_WIDTH-1:0]   dly_d   [CHANNELS][STAGES];
    logic [CHANNELS*OUT_WIDTH-1:0] sat_data;
    logic signed [ACC_WIDTH-1:0]   rnd, shf;
    logic [6:0]                    rate_c;
    logic                          chg, clr;

    assign rate_c = (cic_if.rate < MIN_R) ? MIN_R : (cic_if.rate > MAX_R) ? MAX_R : cic_if.rate;
    assign chg    = (state_q != FLUSH) && ((rate_c != active_rate_q) || (cic_if.shift != active_shift_q));
    assign clr    = (state_q == FLUSH) || chg;

    always_comb begin
        sat_data = '0;
        rnd      = '0;
        shf      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rnd = comb_q[c][STAGES-1] +
                  ((active_shift_q == 6'd0) ? '0 : $signed(ACC_WIDTH'(1) << (active_shift_q - 6'd1)));
            shf = rnd >>> active_shift_q;
            sat_data[c*OUT_WIDTH +: OUT_WIDTH] = (shf > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] :
                                                 (shf < SAT_MIN) ? SAT_MIN[OUT_WIDTH-1:0] :
                                                 shf[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d        = chg ? FLUSH : (state_q == FLUSH) ? WARMUP_S : state_q;
        active_rate_d  = chg ? rate_c : active_rate_q;
        active_shift_d = chg ? cic_if.shift : active_shift_q;
        sample_no_d    = sample_no_q;
        wcnt_d         = wcnt_q;
        dump_d         = 1'b0;
        emit_d         = 1'b0;
        out_strobe_d   = 1'b0;
        out_data_d     = out_data_q;
        integ_d        = integ_q;
        comb_d         = comb_q;
        dly_d          = dly_q;
        if (clr) begin
            sample_no_d = '0;
            wcnt_d      = '0;
            integ_d     = '{default: '0};
            comb_d      = '{default: '0};
            dly_d       = '{default: '0};
        end else begin
            if (cic_if.in_strobe) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    integ_d[c][0] = integ_q[c][0] + ACC_WIDTH'($signed(cic_if.in_data[c*IN_WIDTH +: IN_WIDTH]));
                    for (int s = 1; s < STAGES; s++)
                        integ_d[c][s] = integ_q[c][s] + integ_q[c][s-1];
                end
                dump_d      = (sample_no_q == active_rate_q - 7'd1);
                sample_no_d = dump_d ? '0 : sample_no_q + 7'd1;
            end
            // comb stages form a pipeline: each consumes its predecessor's pre-update value
            if (dump_q) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    comb_d[c][0] = integ_q[c][STAGES-1] - dly_q[c][0];
                    dly_d[c][0]  = integ_q[c][STAGES-1];
                    for (int s = 1; s < STAGES; s++) begin
                        comb_d[c][s] = comb_q[c][s-1] - dly_q[c][s];
                        dly_d[c][s]  = comb_q[c][s-1];
                    end
                end
                emit_d = (state_q == RUN);
                if (state_q == WARMUP_S) begin
                    wcnt_d = wcnt_q + WC_W'(1);
                    if (wcnt_q == WC_W'(WARMUP-1))
                        state_d = RUN;
                end
            end
            if (emit_q) begin
                out_strobe_d = 1'b1;
                out_data_d   = sat_data;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q        <= FLUSH;
            active_rate_q  <= rate_c;
            active_shift_q <= cic_if.shift;
            sample_no_q    <= '0;
            wcnt_q         <= '0;
            dump_q         <= 1'b0;
            emit_q         <= 1'b0;
            out_strobe_q   <= 1'b0;
            out_data_q     <= '0;
            integ_q        <= '{default: '0};
            comb_q         <= '{default: '0};
            dly_q          <= '{default: '0};
        end else begin
            state_q        <= state_d;
            active_rate_q  <= active_rate_d;
            active_shift_q <= active_shift_d;
            sample_no_q    <= sample_no_d;
            wcnt_q         <= wcnt_d;
            dump_q         <= dump_d;
            emit_q         <= emit_d;
            out_strobe_q   <= out_strobe_d;
            out_data_q     <= out_data_d;
            integ_q        <= integ_d;
            comb_q         <= comb_d;
            dly_q          <= dly_d;
        end
    end

    assign cic_if.out_strobe = out_strobe_q;
    assign cic_if.out_data   = out_data_q;
    assign cic_if.busy       = (state_q != RUN);
endmodule

// File: tb/tb_cic_dec_var.sv
// tb_cic_dec_var: directed checks of gain, rounding, saturation, warm-up, flush, clamping and latency.
module tb_cic_dec_var;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cic_dec_var_if #(.CHANNELS(2), .IN_WIDTH(18), .OUT_WIDTH(18)) bus ();
    cic_dec_var dut (.clock_i(clk), .reset_n_i(rst_n), .cic_if(bus));

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_out = 0, rise = 0, prev_rise = 0, fall = 0, scyc = 0, base = 0;
    logic prev_os = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_strobe && !prev_os) begin
            n_out++;
            prev_rise = rise;
            rise = cyc;
        end
        if (!bus.out_strobe && prev_os) fall = cyc;
        prev_os = bus.out_strobe;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ch(input int k);
        return int'($signed(bus.out_data[k*18 +: 18]));
    endfunction

    task automatic send(input int a, input int b);
        bus.in_strobe = 1'b1;
        bus.in_data   = {18'(b), 18'(a)};
        @(negedge clk);
        scyc = cyc;
        bus.in_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input int n, input int a, input int b);
        repeat (n) send(a, b);
    endtask

    task automatic cfg(input int r, input int s);
        bus.rate  = 7'(r);
        bus.shift = 6'(s);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.rate = 7'd8;
        bus.shift = 6'd15;
        bus.in_strobe = 1'b0;
        bus.in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_strobe", bus.out_strobe, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_busy", bus.busy, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(80, 1000, 1000);
        check("dc_warm_nout", n_out, 0);
        check("dc_busy", bus.busy, 0);
        run(24, 1000, 1000);
        check("dc_nout", n_out, 3);
        check("dc_ch0", ch(0), 1000);
        check("dc_ch1", ch(1), 1000);
        check("dc_period", rise - prev_rise, 32);

        cfg(8, 14);
        check("sat_flush_busy", bus.busy, 1);
        base = n_out;
        run(96, 131071, -131072);
        check("sat_nout", n_out - base, 2);
        check("sat_pos0", ch(0), 131071);
        check("sat_neg1", ch(1), -131072);
        run(96, -131072, 131071);
        check("sat_neg0", ch(0), -131072);
        check("sat_pos1", ch(1), 131071);

        cfg(2, 5);
        run(22, 3, -5);
        check("rnd5_ch0", ch(0), 3);
        check("rnd5_ch1", ch(1), -5);
        cfg(2, 7);
        run(22, 3, -3);
        check("rnd7_ch0", ch(0), 1);
        check("rnd7_ch1", ch(1), -1);

        cfg(10, 16);
        base = n_out;
        run(110, 1000, 1000);
        check("r10_nout", n_out - base, 1);
        check("r10_ch0", ch(0), 1526);
        run(5, 1000, 1000);
        bus.rate = 7'd40;
        bus.shift = 6'd26;
        @(negedge clk);
        check("chg_busy", bus.busy, 1);
        base = n_out;
        repeat (2) @(negedge clk);
        run(400, 1000, 1000);
        check("chg_warm_nout", n_out - base, 0);
        check("chg_busy_low", bus.busy, 0);
        run(40, 1000, 1000);
        check("chg_nout", n_out - base, 1);
        check("chg_ch1", ch(1), 1526);
        check("chg_align", rise - scyc, 2);

        cfg(1, 5);
        base = n_out;
        run(24, 3, -5);
        check("clo_nout", n_out - base, 2);
        check("clo_ch0", ch(0), 3);
        check("clo_period", rise - prev_rise, 8);
        bus.rate = 7'd2;
        repeat (2) @(negedge clk);
        check("clo_noflush", bus.busy, 0);
        base = n_out;
        run(4, 3, -5);
        check("clo_cont", n_out - base, 2);

        cfg(100, 26);
        base = n_out;
        run(480, 1000, 1000);
        check("chi_nout", n_out - base, 2);
        check("chi_ch0", ch(0), 1526);
        check("chi_period", rise - prev_rise, 160);
        bus.rate = 7'd40;
        repeat (2) @(negedge clk);
        check("chi_noflush", bus.busy, 0);

        cfg(2, 5);
        run(22, 3, -5);
        check("rm_busy_run", bus.busy, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rm_data", bus.out_data, 0);
        check("rm_strobe", bus.out_strobe, 0);
        check("rm_busy", bus.busy, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = n_out;
        run(20, 3, -5);
        check("rm_warm_nout", n_out - base, 0);
        run(2, 3, -5);
        check("rm_nout", n_out - base, 1);
        check("rm_ch1", ch(1), -5);

        cfg(4, 10);
        run(44, 7, 7);
        @(negedge clk);
        check("lat_rise", rise - scyc, 2);
        check("lat_width", fall - rise, 1);
        check("lat_ch0", ch(0), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
